route_demux: RTL and testbench
==============================

# route_demux

Parametrised 1-to-N routing demultiplexer for the CPLD model, routing a W-bit `signal` to one of CHANNELS output lanes while every other lane carries its own default value. Selection changes go through a request/acknowledge handshake with a programmable break-before-make dead interval, during which all lanes carry defaults. This ensures that no two lanes ever carry `signal` across a switch. The block sits between product-term/feedback routing logic and the macrocell inputs.

## Interface
Parameters:
- `WIDTH`, 1: bits per lane.
- `CHANNELS`, 4: number of output lanes, 2..16.
- `DEAD`, 1: break-before-make cycles, 0..255.
- `SELW`, `$clog2(CHANNELS)`: selector width (derived; do not override).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `signal`, in, WIDTH: routed value.
- `defaults`, in, CHANNELS*WIDTH: per-lane default; lane k is bits [k*WIDTH +: WIDTH].
- `sel_req`, in, 1: selection-change request, sampled when `busy`=0.
- `sel_new`, in, SELW: requested lane.
- `sel_cur`, out, SELW: committed lane.
- `sel_ack`, out, 1: one-cycle completion pulse.
- `sel_err`, out, 1: one-cycle pulse, coincident with `sel_ack`, for an invalid request.
- `busy`, out, 1: high while in BREAK.
- `q`, out, CHANNELS*WIDTH: lane outputs.

## Operation
- The FSM has two states: ROUTE and BREAK. It uses a dead counter of width `$clog2(DEAD+1)`.
- ROUTE: lane `sel_cur` = `signal`; every other lane k = `defaults` lane k.
- BREAK: every lane = its default; `busy`=1.
- `sel_req`=1 in ROUTE is handled by case:
  - `sel_new` ≥ CHANNELS: reject. `sel_cur` is unchanged; `sel_ack`=`sel_err`=1 next cycle; stay in ROUTE.
  - `sel_new` == `sel_cur`: `sel_ack`=1 next cycle; no break; `sel_err`=0.
  - Otherwise, with DEAD=0: commit `sel_cur`=`sel_new` at that edge; `sel_ack`=1 next cycle.
  - Otherwise, with DEAD>0: latch `sel_new` into a pending register, load the counter with DEAD−1, and enter BREAK.
- BREAK: the counter decrements each cycle. On the edge where it reads 0, commit pending to `sel_cur`, go to ROUTE, and assert `sel_ack` for the following cycle.
- `sel_req` while `busy`=1 is ignored. It is not queued and produces no ack. `sel_new` is don't-care.
- `defaults` and `signal` are never registered by the routing path itself (see Configuration).
- Reset values: state ROUTE, `sel_cur`=0, counter 0, pending 0, `sel_ack`=0, `sel_err`=0, `busy`=0.
- `rst` in BREAK aborts the switch. No ack is issued, `sel_cur`=0, and routing resumes to lane 0 on the cycle after reset.
- `sel_req` held high continuously: each ROUTE cycle in which `busy`=0 is a fresh request.

## Timing
- A request sampled at edge t (DEAD=D>0) produces:
  - BREAK on cycles t+1 .. t+D, with `busy`=1.
  - The new route and `sel_ack`=1 on cycle t+D+1.
  - `busy`=0 on cycle t+D+1; a new request can be sampled at edge t+D+1.
- D=0, same-lane, or invalid request: ack on cycle t+1, with no interval where all lanes are defaults.
- `sel_cur` changes on the same edge that begins the ack cycle.
- `sel_ack` and `sel_err` are registered. They are never high for two consecutive cycles from one request.
- Lane path latency: 0 cycles (combinational) without the macro, 1 cycle with it.

## Configuration
- Macro: `ROUTE_DEMUX_REGOUT_EN`.
- Defined: `q` is registered. Each lane is captured from the routing logic every cycle, giving one extra cycle of latency on both `signal` and `defaults`. `q` resets to all zeros. The BREAK interval as seen on `q` is shifted by one cycle but has the same length.
- Undefined: `q` is purely combinational from state, `sel_cur`, `signal` and `defaults`. During and after reset, `q` shows lane 0 = `signal` and the other lanes = defaults.

## Test plan
- Reset, CHANNELS=4, WIDTH=8, `signal`=0xA5, `defaults`={0x44,0x33,0x22,0x11} (lane 3..0) → after reset `sel_cur`=0, `q`={0x44,0x33,0x22,0xA5}, `busy`=0, no ack.
- DEAD=3, request lane 2 at edge t → `q`={0x44,0x33,0x22,0x11} for cycles t+1..t+3 with `busy`=1; cycle t+4 `q`={0x44,0xA5,0x22,0x11}, `sel_ack`=1, `sel_cur`=2.
- Request during BREAK (lane 3 at t+2) → ignored; exactly one ack at t+4; `sel_cur`=2.
- Request lane 0 when `sel_cur`=0, and request lane 5 with CHANNELS=4 (SELW=3 only in the CHANNELS=5 build; use CHANNELS=5 with `sel_new`=6) → ack on next cycle; `sel_err`=0 and 1 respectively; `q` never all-defaults.
- `rst` at t+2 of a DEAD=3 switch → no ack; `sel_cur`=0; lane 0 routed from t+3.
- With `ROUTE_DEMUX_REGOUT_EN`, repeat the second test → each `q` transition is delayed one cycle; `sel_ack` is still at t+4; `q`=0 during reset.

Source files
------------

// File: rtl/route_demux_if.sv
// Bus bundle for route_demux: routed data, per-lane defaults, the
// selection handshake and the lane outputs. The DUT takes the slave modport.
interface route_demux_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4
);
  localparam int SELW = $clog2(CHANNELS);

  logic [WIDTH-1:0]          signal;
  logic [CHANNELS*WIDTH-1:0] defaults;
  logic                      sel_req;
  logic [SELW-1:0]           sel_new;
  logic [SELW-1:0]           sel_cur;
  logic                      sel_ack;
  logic                      sel_err;
  logic                      busy;
  logic [CHANNELS*WIDTH-1:0] q;

  modport master (
    output signal, defaults, sel_req, sel_new,
    input  sel_cur, sel_ack, sel_err, busy, q
  );

  modport slave (
    input  signal, defaults, sel_req, sel_new,
    output sel_cur, sel_ack, sel_err, busy, q
  );
endinterface

// File: rtl/route_demux.sv
// 1-to-N routing demux with break-before-make selection handshake.
// Optional macro ROUTE_DEMUX_REGOUT_EN registers the lane outputs (q).

// Per-lane mux: the lane carries signal only when it is the committed lane
// and the block is routing; otherwise it carries its own default.
module route_demux_lane #(
  parameter int WIDTH = 1,
  parameter int SELW  = 2,
  parameter int LANE  = 0
) (
  input  logic             route,
  input  logic [SELW-1:0]  sel_cur,
  input  logic [WIDTH-1:0] signal,
  input  logic [WIDTH-1:0] dflt,
  output logic [WIDTH-1:0] d
);
  logic hit;

  assign hit = route && (sel_cur == SELW'(LANE));
  assign d   = hit ? signal : dflt;
endmodule

module route_demux #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int DEAD     = 1,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input logic         clk,
  input logic         rst,
  route_demux_if.slave bus
);
  // A zero-length dead interval never uses the counter; keep it 1 bit wide.
  localparam int CNTW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
  localparam logic [SELW:0]   CH_LIM   = (SELW + 1)'(CHANNELS);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(DEAD - 1);

  typedef enum logic {ROUTE, BREAK} state_t;

  state_t          state, state_n;
  logic [SELW-1:0] sel_cur, sel_cur_n;
  logic [SELW-1:0] pend, pend_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic            ack, ack_n;
  logic            err, err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ROUTE;
      sel_cur <= '0;
      pend    <= '0;
      cnt     <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      sel_cur <= sel_cur_n;
      pend    <= pend_n;
      cnt     <= cnt_n;
      ack     <= ack_n;
      err     <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    sel_cur_n = sel_cur;
    pend_n    = pend;
    cnt_n     = cnt;
    ack_n     = 1'b0;
    err_n     = 1'b0;
    case (state)
      ROUTE: begin
        if (bus.sel_req) begin
          if ({1'b0, bus.sel_new} >= CH_LIM) begin
            ack_n = 1'b1;
            err_n = 1'b1;
          end else if (bus.sel_new == sel_cur) begin
            ack_n = 1'b1;
          end else if (DEAD == 0) begin
            sel_cur_n = bus.sel_new;
            ack_n     = 1'b1;
          end else begin
            pend_n  = bus.sel_new;
            cnt_n   = CNT_LOAD;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        // Requests are dropped here; only the dead counter advances.
        if (cnt == '0) begin
          sel_cur_n = pend;
          state_n   = ROUTE;
          ack_n     = 1'b1;
        end else begin
          cnt_n = cnt - CNTW'(1);
        end
      end
      default: state_n = ROUTE;
    endcase
  end

  assign bus.sel_cur = sel_cur;
  assign bus.sel_ack = ack;
  assign bus.sel_err = err;
  assign bus.busy    = (state == BREAK);

  logic [CHANNELS-1:0][WIDTH-1:0] dflt_a;
  logic [CHANNELS-1:0][WIDTH-1:0] lane_d;
  logic                           route;

  assign dflt_a = bus.defaults;
  assign route  = (state == ROUTE);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    route_demux_lane #(
      .WIDTH (WIDTH),
      .SELW  (SELW),
      .LANE  (k)
    ) u_lane (
      .route   (route),
      .sel_cur (sel_cur),
      .signal  (bus.signal),
      .dflt    (dflt_a[k]),
      .d       (lane_d[k])
    );
  end

`ifdef ROUTE_DEMUX_REGOUT_EN
  logic [CHANNELS-1:0][WIDTH-1:0] q_r;

  always_ff @(posedge clk) begin
    if (rst) q_r <= '0;
    else     q_r <= lane_d;
  end

  assign bus.q = q_r;
`else
  assign bus.q = lane_d;
`endif
endmodule

// File: tb/tb_route_demux.sv
// Directed + random bench for route_demux: two builds (4 lanes/DEAD=3 and
// 5 lanes/DEAD=0) checked each cycle against a timeline reference model.
module tb_route_demux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  route_demux_if #(.WIDTH(8), .CHANNELS(4)) ifa ();
  route_demux_if #(.WIDTH(8), .CHANNELS(5)) ifb ();

  route_demux #(.WIDTH(8), .CHANNELS(4), .DEAD(3)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave));
  route_demux #(.WIDTH(8), .CHANNELS(5), .DEAD(0)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave));

  logic [7:0]  sig;
  logic [39:0] dfl;
  logic        req_a, req_b;
  logic [1:0]  new_a;
  logic [2:0]  new_b;

  assign ifa.signal   = sig;
  assign ifa.defaults = dfl[31:0];
  assign ifa.sel_req  = req_a;
  assign ifa.sel_new  = new_a;
  assign ifb.signal   = sig;
  assign ifb.defaults = dfl;
  assign ifb.sel_req  = req_b;
  assign ifb.sel_new  = new_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a switch in progress is a pending lane plus the edge
  // number at which it lands; lanes are all-defaults until then.
  int          nch[2] = '{4, 5};
  int          dd[2]  = '{3, 0};
  int          m_cur[2], m_pend[2], m_done[2];
  bit          m_prog[2], m_ack[2], m_err[2];
  logic [39:0] m_qreg[2];
  int          edge_n = 0;

  function automatic logic [39:0] lanes(int d, bit brk, int cur);
    logic [39:0] r = dfl;
    if (!brk) r[cur*8 +: 8] = sig;
    for (int k = nch[d]; k < 5; k++) r[k*8 +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [39:0] q_exp(int d);
`ifdef ROUTE_DEMUX_REGOUT_EN
    return m_qreg[d];
`else
    return lanes(d, m_prog[d], m_cur[d]);
`endif
  endfunction

  task automatic model_edge(int d, bit r, bit req, int ns);
    m_qreg[d] = r ? 40'h0 : lanes(d, m_prog[d], m_cur[d]);
    m_ack[d]  = 1'b0;
    m_err[d]  = 1'b0;
    if (r) begin
      m_cur[d]  = 0;
      m_prog[d] = 1'b0;
    end else if (m_prog[d]) begin
      if (edge_n == m_done[d]) begin
        m_cur[d]  = m_pend[d];
        m_prog[d] = 1'b0;
        m_ack[d]  = 1'b1;
      end
    end else if (req) begin
      m_ack[d] = 1'b1;
      if (ns >= nch[d]) m_err[d] = 1'b1;
      else if (ns != m_cur[d]) begin
        if (dd[d] == 0) m_cur[d] = ns;
        else begin
          m_ack[d]  = 1'b0;
          m_prog[d] = 1'b1;
          m_pend[d] = ns;
          m_done[d] = edge_n + dd[d];
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [39:0] got, logic [39:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    #1;
    model_edge(0, rst, req_a, int'(new_a));
    model_edge(1, rst, req_b, int'(new_b));
    chk("a.cur",  40'(ifa.sel_cur), 40'(m_cur[0]));
    chk("a.ack",  40'(ifa.sel_ack), 40'(m_ack[0]));
    chk("a.err",  40'(ifa.sel_err), 40'(m_err[0]));
    chk("a.busy", 40'(ifa.busy),    40'(m_prog[0]));
    chk("a.q",    40'(ifa.q),       q_exp(0));
    chk("b.cur",  40'(ifb.sel_cur), 40'(m_cur[1]));
    chk("b.ack",  40'(ifb.sel_ack), 40'(m_ack[1]));
    chk("b.err",  40'(ifb.sel_err), 40'(m_err[1]));
    chk("b.busy", 40'(ifb.busy),    40'(m_prog[1]));
    chk("b.q",    40'(ifb.q),       q_exp(1));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_cur[d] = 0; m_pend[d] = 0; m_done[d] = 0;
      m_prog[d] = 1'b0; m_ack[d] = 1'b0; m_err[d] = 1'b0; m_qreg[d] = '0;
    end
    sig = 8'hA5;
    dfl = 40'h55_44_33_22_11;
    req_a = 1'b0; new_a = 2'd0;
    req_b = 1'b0; new_b = 3'd0;
    rst = 1'b1;

    // Reset state
    step();
    step();
`ifdef ROUTE_DEMUX_REGOUT_EN
    chk("rst.q", 40'(ifa.q), 40'h0);
`else
    chk("rst.q", 40'(ifa.q), 40'h44_33_22_A5);
`endif
    chk("rst.cur", 40'(ifa.sel_cur), 40'h0);
    rst = 1'b0;
    step();

    // DEAD=3 switch to lane 2, with an ignored request mid-break
    req_a = 1'b1; new_a = 2'd2;
    step();
    chk("brk.busy", 40'(ifa.busy), 40'h1);
`ifndef ROUTE_DEMUX_REGOUT_EN
    chk("brk.q", 40'(ifa.q), 40'h44_33_22_11);
`endif
    req_a = 1'b0;
    step();
    req_a = 1'b1; new_a = 2'd3;
    step();
    req_a = 1'b0;
    step();
    chk("sw.ack", 40'(ifa.sel_ack), 40'h1);
    chk("sw.cur", 40'(ifa.sel_cur), 40'h2);
`ifdef ROUTE_DEMUX_REGOUT_EN
    chk("sw.q", 40'(ifa.q), 40'h44_33_22_11);
`else
    chk("sw.q", 40'(ifa.q), 40'h44_A5_22_11);
`endif
    step();
    chk("sw.ack1", 40'(ifa.sel_ack), 40'h0);
    chk("sw.cur1", 40'(ifa.sel_cur), 40'h2);

    // DEAD=0 build: same lane, invalid lane, then a real switch
    req_b = 1'b1; new_b = 3'd0;
    step();
    chk("same.err", 40'(ifb.sel_err), 40'h0);
    new_b = 3'd6;
    step();
    chk("inv.err", 40'(ifb.sel_err), 40'h1);
    chk("inv.cur", 40'(ifb.sel_cur), 40'h0);
    new_b = 3'd4;
    step();
    chk("d0.cur", 40'(ifb.sel_cur), 40'h4);
    req_b = 1'b0;
    step();

    // Reset aborts a switch in progress
    req_a = 1'b1; new_a = 2'd1;
    step();
    req_a = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.cur", 40'(ifa.sel_cur), 40'h0);
    chk("abort.ack", 40'(ifa.sel_ack), 40'h0);
    step();
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      sig = 8'($urandom);
      if (($urandom % 8) == 0) dfl = {8'($urandom), 32'($urandom)};
      req_a = (($urandom % 3) == 0);
      new_a = 2'($urandom);
      req_b = (($urandom % 3) == 0);
      new_b = 3'($urandom);
      rst   = (($urandom % 60) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
